segmented_adder: RTL and testbench

SEGMENTED_ADDER -- requirements
Module: segmented_adder

---
 rtl/segmented_adder_pkg.sv | 22 ++
 rtl/segmented_adder_chunk_adder.sv | 44 ++++
 rtl/segmented_adder.sv | 153 +++++++++++++++
 tb/tb_segmented_adder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/segmented_adder_pkg.sv
// ============================================================================
// Module      : segmented_adder_pkg
// Description : Shared FSM state encoding and default sizing for the
//               segmented adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package segmented_adder_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int CHUNK_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } adderState_t;

endpackage : segmented_adder_pkg

`default_nettype wire

// File: rtl/segmented_adder_chunk_adder.sv
// ============================================================================
// Module      : chunk_adder
// Description : Combinational CHUNK-bit adder exposing the carry into its MSB
//               so the caller can derive signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chunk_adder
  import segmented_adder_pkg::*;
#(
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             carryIn,
  output logic [CHUNK-1:0] sum,
  output logic             carryOut,
  output logic             msbCarryIn
);

  generate
    if (CHUNK > 1) begin : g_wide
      logic [CHUNK-1:0] w_low;
      logic             w_topSum;

      // Add everything below the MSB first so its carry is visible on its own.
      assign w_low      = {1'b0, a[CHUNK-2:0]} + {1'b0, b[CHUNK-2:0]}
                        + {{(CHUNK-1){1'b0}}, carryIn};
      assign msbCarryIn = w_low[CHUNK-1];
      assign w_topSum   = a[CHUNK-1] ^ b[CHUNK-1] ^ w_low[CHUNK-1];
      assign sum        = {w_topSum, w_low[CHUNK-2:0]};
      assign carryOut   = (a[CHUNK-1] & b[CHUNK-1])
                        | (w_low[CHUNK-1] & (a[CHUNK-1] ^ b[CHUNK-1]));
    end else begin : g_single
      assign msbCarryIn = carryIn;
      assign sum        = a ^ b ^ carryIn;
      assign carryOut   = (a[0] & b[0]) | (carryIn & (a[0] ^ b[0]));
    end
  endgenerate

endmodule : chunk_adder

`default_nettype wire

// File: rtl/segmented_adder.sv
// ============================================================================
// Module      : segmented_adder
// Description : Multi-cycle WIDTH-bit adder processing CHUNK bits per cycle
//               through one shared chunk_adder. Optional macro
//               SEGMENTED_ADDER_OVERFLOW_EN adds the signed Overflow output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module segmented_adder
  import segmented_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             CarryIn,
  output logic             OutValid,
  input  logic             OutReady,
`ifdef SEGMENTED_ADDER_OVERFLOW_EN
  output logic             Overflow,
`endif
  output logic [WIDTH-1:0] Sum,
  output logic             CarryOut
);

  localparam int NSEG = WIDTH / CHUNK;
  localparam int IDXW = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSEG - 1);

  adderState_t      r_state;
  logic             r_inReady;
  logic             r_outValid;
  logic [WIDTH-1:0] r_opX;
  logic [WIDTH-1:0] r_opY;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_carryOut;
  logic [IDXW-1:0]  r_idx;
`ifdef SEGMENTED_ADDER_OVERFLOW_EN
  logic             r_overflow;
`endif

  logic [CHUNK-1:0] w_xSeg [NSEG];
  logic [CHUNK-1:0] w_ySeg [NSEG];
  logic [CHUNK-1:0] w_segX;
  logic [CHUNK-1:0] w_segY;
  logic [CHUNK-1:0] w_segSum;
  logic             w_segCarry;
  logic             w_segMsbCarry;
  logic [WIDTH-1:0] w_sumNext;

  // Only the segment addressed by r_idx is replaced; others keep their value.
  generate
    for (genvar g = 0; g < NSEG; g++) begin : g_seg
      assign w_xSeg[g] = r_opX[g*CHUNK +: CHUNK];
      assign w_ySeg[g] = r_opY[g*CHUNK +: CHUNK];
      assign w_sumNext[g*CHUNK +: CHUNK] =
        (r_idx == IDXW'(g)) ? w_segSum : r_sum[g*CHUNK +: CHUNK];
    end
  endgenerate

  assign w_segX = w_xSeg[r_idx];
  assign w_segY = w_ySeg[r_idx];

  chunk_adder #(
    .CHUNK      (CHUNK)
  ) u_chunkAdder (
    .a          (w_segX),
    .b          (w_segY),
    .carryIn    (r_carry),
    .sum        (w_segSum),
    .carryOut   (w_segCarry),
    .msbCarryIn (w_segMsbCarry)
  );

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_state    <= IDLE;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_opX      <= '0;
      r_opY      <= '0;
      r_sum      <= '0;
      r_carry    <= 1'b0;
      r_carryOut <= 1'b0;
      r_idx      <= '0;
`ifdef SEGMENTED_ADDER_OVERFLOW_EN
      r_overflow <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (InValid) begin
            r_opX      <= X;
            r_opY      <= Y;
            r_carry    <= CarryIn;
            r_idx      <= '0;
            r_sum      <= '0;
            r_carryOut <= 1'b0;
`ifdef SEGMENTED_ADDER_OVERFLOW_EN
            r_overflow <= 1'b0;
`endif
            r_inReady  <= 1'b0;
            r_state    <= ADD;
          end
        end
        ADD: begin
          r_sum   <= w_sumNext;
          r_carry <= w_segCarry;
          if (r_idx == LAST_IDX) begin
            r_carryOut <= w_segCarry;
`ifdef SEGMENTED_ADDER_OVERFLOW_EN
            r_overflow <= w_segCarry ^ w_segMsbCarry;
`endif
            r_outValid <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        DONE: begin
          if (OutReady) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_outValid <= 1'b0;
          r_inReady  <= 1'b1;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign InReady  = r_inReady;
  assign OutValid = r_outValid;
  assign Sum      = r_sum;
  assign CarryOut = r_carryOut;
`ifdef SEGMENTED_ADDER_OVERFLOW_EN
  assign Overflow = r_overflow;
`endif

endmodule : segmented_adder

`default_nettype wire

// File: tb/tb_segmented_adder.sv
// ============================================================================
// Module      : tb_segmented_adder
// Description : Self-checking bench for segmented_adder (WIDTH=64, CHUNK=16);
//               Overflow checks active with SEGMENTED_ADDER_OVERFLOW_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_segmented_adder;

  localparam int W    = 64;
  localparam int NSEG = 4;

  logic          Clock = 1'b0;
  logic          ResetN;
  logic          InValid;
  logic          InReady;
  logic [W-1:0]  X;
  logic [W-1:0]  Y;
  logic          CarryIn;
  logic          OutValid;
  logic          OutReady;
  logic [W-1:0]  Sum;
  logic          CarryOut;
`ifdef SEGMENTED_ADDER_OVERFLOW_EN
  logic          Overflow;
`endif

  int errors = 0;
  int checks = 0;

  always #5 Clock = ~Clock;

  segmented_adder #(
    .WIDTH    (W),
    .CHUNK    (16)
  ) dut (
    .Clock    (Clock),
    .ResetN   (ResetN),
    .InValid  (InValid),
    .InReady  (InReady),
    .X        (X),
    .Y        (Y),
    .CarryIn  (CarryIn),
    .OutValid (OutValid),
    .OutReady (OutReady),
`ifdef SEGMENTED_ADDER_OVERFLOW_EN
    .Overflow (Overflow),
`endif
    .Sum      (Sum),
    .CarryOut (CarryOut)
  );

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ov;
    int           hold;
  } vec_t;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the block idle; returns after the result is consumed.
  task automatic runOp(input logic [W-1:0] x, input logic [W-1:0] y, input logic cin,
                       input logic [W-1:0] expSum, input logic expCout, input logic expOv,
                       input int hold);
    int lat;
    logic [W-1:0] heldSum;
    logic heldCout;
    check("inReady_idle", W'(InReady), W'(1));
    X = x; Y = y; CarryIn = cin; InValid = 1'b1;
    @(negedge Clock);
    InValid = 1'b0;
    X = {$urandom, $urandom}; Y = {$urandom, $urandom}; CarryIn = 1'($urandom);
    check("inReady_busy", W'(InReady), W'(0));
    check("outValid_busy", W'(OutValid), W'(0));
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge Clock);
      if (OutValid) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) begin
      check("timeout_outValid", W'(0), W'(1));
      return;
    end
    check("latency", W'(lat), W'(NSEG));
    check("sum", Sum, expSum);
    check("carryOut", W'(CarryOut), W'(expCout));
`ifdef SEGMENTED_ADDER_OVERFLOW_EN
    check("overflow", W'(Overflow), W'(expOv));
`else
    if (expOv === 1'bx) check("ov_unused", W'(0), W'(1));
`endif
    heldSum = Sum;
    heldCout = CarryOut;
    for (int h = 0; h < hold; h++) begin
      X = {$urandom, $urandom}; Y = {$urandom, $urandom}; InValid = 1'($urandom);
      @(negedge Clock);
      check("hold_sum", Sum, heldSum);
      check("hold_cout", W'(CarryOut), W'(heldCout));
      check("hold_inReady", W'(InReady), W'(0));
      check("hold_outValid", W'(OutValid), W'(1));
    end
    InValid = 1'b0;
    OutReady = 1'b1;
    @(negedge Clock);
    OutReady = 1'b0;
    check("release_outValid", W'(OutValid), W'(0));
    check("release_inReady", W'(InReady), W'(1));
  endtask

  initial begin
    vec_t vecs[$];
    logic [W-1:0] rx, ry;
    logic rc;
    logic [W:0] full;
    int seen;

    vecs.push_back('{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 64'h1, 1'b1, 1'b1, 0});
    vecs.push_back('{64'd231, 64'd698, 1'b0, 64'd929, 1'b0, 1'b0, 0});
    vecs.push_back('{64'd999999999, 64'd1, 1'b0, 64'd1000000000, 1'b0, 1'b0, 0});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0, 0});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                     64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 0});
    vecs.push_back('{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 0});
    vecs.push_back('{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1, 0});
    vecs.push_back('{64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0,
                     64'h1234_5678_9ABC_DF00, 1'b0, 1'b0, 6});

    ResetN = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    X = '0; Y = '0; CarryIn = 1'b0;
    repeat (3) @(negedge Clock);
    check("rst_inReady", W'(InReady), W'(1));
    check("rst_outValid", W'(OutValid), W'(0));
    check("rst_sum", Sum, '0);
    check("rst_cout", W'(CarryOut), W'(0));
`ifdef SEGMENTED_ADDER_OVERFLOW_EN
    check("rst_ov", W'(Overflow), W'(0));
`endif
    // First vector is offered on the very first edge after release.
    ResetN = 1'b1;
    foreach (vecs[i])
      runOp(vecs[i].x, vecs[i].y, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].ov, vecs[i].hold);

    for (int i = 0; i < 30; i++) begin
      rx = {$urandom, $urandom};
      ry = {$urandom, $urandom};
      rc = 1'($urandom);
      case ($urandom_range(0, 5))
        0: rx = '1;
        1: ry = ~rx;
        default: ;
      endcase
      full = {1'b0, rx} + {1'b0, ry} + (W + 1)'(rc);
      runOp(rx, ry, rc, full[W-1:0], full[W],
            (rx[W-1] == ry[W-1]) && (full[W-1] != rx[W-1]), int'($urandom_range(0, 2)));
    end

    // Reset in the middle of an add: two segments already written.
    X = 64'hDEAD_BEEF_CAFE_F00D; Y = 64'h1357_9BDF_2468_ACE0; CarryIn = 1'b1; InValid = 1'b1;
    @(negedge Clock);
    InValid = 1'b0;
    repeat (2) @(negedge Clock);
    #2 ResetN = 1'b0;
    #1;
    check("midrst_outValid", W'(OutValid), W'(0));
    check("midrst_sum", Sum, '0);
    check("midrst_cout", W'(CarryOut), W'(0));
`ifdef SEGMENTED_ADDER_OVERFLOW_EN
    check("midrst_ov", W'(Overflow), W'(0));
`endif
    @(negedge Clock);
    ResetN = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      if (OutValid) seen++;
    end
    check("midrst_noValid", W'(seen), W'(0));
    runOp(64'd1, 64'd1, 1'b0, 64'd2, 1'b0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_segmented_adder

`default_nettype wire
